// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED shift-pattern sequencer.
package led_seq_pkg;

  localparam int NB_LED = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROT_L = 2'd1,
    ST_ROT_R = 2'd2,
    ST_PING  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2
  } colour_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_PING   = 2;
  localparam int BTN_COLOUR = 3;
  localparam int SW_RUN     = 0;

  function automatic colour_t next_colour(input colour_t c);
    case (c)
      COL_RED:   return COL_GREEN;
      COL_GREEN: return COL_BLUE;
      default:   return COL_RED;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Switch-selected shift tick: counts to the chosen limit, clears on a speed change,
// emits a combinational tick for same-edge pattern update plus a registered one-cycle pulse.
module led_tick_gen #(
  parameter int          NB_COUNT = 32,
  parameter int unsigned LIMIT_0  = 2**22,
  parameter int unsigned LIMIT_1  = 2**21,
  parameter int unsigned LIMIT_2  = 2**20,
  parameter int unsigned LIMIT_3  = 2**19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       tick,
  output logic       valid
);

  logic [NB_COUNT-1:0] count;
  logic [NB_COUNT-1:0] limit;
  logic [1:0]          speed_prev;
  logic                speed_change;

  always_comb begin
    case (speed)
      2'd0:    limit = NB_COUNT'(LIMIT_0);
      2'd1:    limit = NB_COUNT'(LIMIT_1);
      2'd2:    limit = NB_COUNT'(LIMIT_2);
      default: limit = NB_COUNT'(LIMIT_3);
    endcase
  end

  assign speed_change = (speed != speed_prev);
  assign tick = enable && !speed_change && (count == limit - NB_COUNT'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      speed_prev <= 2'd0;
      valid      <= 1'b0;
    end else begin
      speed_prev <= speed;
      valid      <= tick;
      if (speed_change || tick) begin
        count <= '0;
      end else if (enable) begin
        count <= count + NB_COUNT'(1);
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer top: button-driven mode FSM, pattern shifter and colour-bank routing.
// Define LED_SEQ_SYNC_EN to pass i_sw/i_btn through a 2-flop synchronizer first.
module led_seq_ctrl #(
  parameter int          NB_LED   = led_seq_pkg::NB_LED,
  parameter int          NB_COUNT = 32,
  parameter int unsigned LIMIT_0  = 2**22,
  parameter int unsigned LIMIT_1  = 2**21,
  parameter int unsigned LIMIT_2  = 2**20,
  parameter int unsigned LIMIT_3  = 2**19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_sw,
  input  logic [3:0]        i_btn,
  output logic [NB_LED-1:0] o_led,
  output logic [NB_LED-1:0] o_led_g,
  output logic [NB_LED-1:0] o_led_b,
  output logic              o_valid,
  output logic [1:0]        o_state
);
  import led_seq_pkg::*;

  logic [3:0] sw_use;
  logic [3:0] btn_use;

`ifdef LED_SEQ_SYNC_EN
  logic [3:0] sw_meta, sw_sync, btn_meta, btn_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= i_sw;
      sw_sync  <= sw_meta;
      btn_meta <= i_btn;
      btn_sync <= btn_meta;
    end
  end

  assign sw_use  = sw_sync;
  assign btn_use = btn_sync;
`else
  assign sw_use  = i_sw;
  assign btn_use = i_btn;
`endif

  logic unused_sw_bit;
  assign unused_sw_bit = sw_use[3];

  state_t            state, state_next;
  dir_t              dir, dir_next;
  colour_t           colour, colour_next;
  logic [NB_LED-1:0] pattern, pattern_next;
  logic [NB_LED-1:0] led_r, led_g, led_b;
  logic [NB_LED-1:0] led_r_next, led_g_next, led_b_next;
  logic [3:0]        btn_prev;
  logic [3:0]        btn_edge;
  logic              tick;

  assign btn_edge = btn_use & ~btn_prev;

  led_tick_gen #(
    .NB_COUNT (NB_COUNT),
    .LIMIT_0  (LIMIT_0),
    .LIMIT_1  (LIMIT_1),
    .LIMIT_2  (LIMIT_2),
    .LIMIT_3  (LIMIT_3)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable ((state != ST_IDLE) && sw_use[SW_RUN]),
    .speed  (sw_use[2:1]),
    .tick   (tick),
    .valid  (o_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir      <= DIR_LEFT;
      colour   <= COL_RED;
      pattern  <= NB_LED'(1);
      btn_prev <= '0;
      led_r    <= '0;
      led_g    <= '0;
      led_b    <= '0;
    end else begin
      state    <= state_next;
      dir      <= dir_next;
      colour   <= colour_next;
      pattern  <= pattern_next;
      btn_prev <= btn_use;
      led_r    <= led_r_next;
      led_g    <= led_g_next;
      led_b    <= led_b_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    dir_next     = dir;
    colour_next  = colour;
    pattern_next = pattern;
    led_r_next   = '0;
    led_g_next   = '0;
    led_b_next   = '0;

    // The shift uses the mode in force before any coincident button edge.
    if (tick) begin
      case (state)
        ST_ROT_L: pattern_next = {pattern[NB_LED-2:0], pattern[NB_LED-1]};
        ST_ROT_R: pattern_next = {pattern[0], pattern[NB_LED-1:1]};
        ST_PING: begin
          if (dir == DIR_LEFT) begin
            if (pattern[NB_LED-1]) begin
              dir_next     = DIR_RIGHT;
              pattern_next = pattern >> 1;
            end else begin
              pattern_next = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              dir_next     = DIR_LEFT;
              pattern_next = pattern << 1;
            end else begin
              pattern_next = pattern >> 1;
            end
          end
        end
        default: ;
      endcase
    end

    if (btn_edge[BTN_LEFT]) begin
      state_next = ST_ROT_L;
    end else if (btn_edge[BTN_RIGHT]) begin
      state_next = ST_ROT_R;
    end else if (btn_edge[BTN_PING]) begin
      state_next = ST_PING;
    end

    if (state_next == ST_PING && state != ST_PING) begin
      dir_next = DIR_LEFT;
    end

    if (btn_edge[BTN_COLOUR]) begin
      colour_next = next_colour(colour);
    end

    if (state_next != ST_IDLE) begin
      case (colour_next)
        COL_GREEN: led_g_next = pattern_next;
        COL_BLUE:  led_b_next = pattern_next;
        default:   led_r_next = pattern_next;
      endcase
    end
  end

  assign o_led   = led_r;
  assign o_led_g = led_g;
  assign o_led_b = led_b;
  assign o_state = state;

endmodule
